// File: rtl/blit_engine_if.sv
// Draw-command, source-ROM, frame-buffer and VGA signals shared between
// the game control FSM side and the blit engine.
interface blit_engine_if;
  logic        copy_enable;
  logic        print_screen;
  logic [1:0]  memory_select;
  logic        draw_stage, draw_tile, draw_explosion, draw_bomb;
  logic        draw_p1, draw_p1_hp, draw_p2, draw_p2_hp;
  logic        black;
  logic [7:0]  origin_x;
  logic [6:0]  origin_y;
  logic [14:0] sprite_base;
  logic [14:0] src_addr;
  logic [2:0]  src_data;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        finished;
  logic        busy;

  modport slave (
    input  copy_enable, print_screen, memory_select,
           draw_stage, draw_tile, draw_explosion, draw_bomb,
           draw_p1, draw_p1_hp, draw_p2, draw_p2_hp,
           black, origin_x, origin_y, sprite_base, src_data,
    output src_addr, fb_we, fb_addr, fb_data,
           vga_plot, vga_x, vga_y, vga_colour, finished, busy
  );

  modport master (
    output copy_enable, print_screen, memory_select,
           draw_stage, draw_tile, draw_explosion, draw_bomb,
           draw_p1, draw_p1_hp, draw_p2, draw_p2_hp,
           black, origin_x, origin_y, sprite_base, src_data,
    input  src_addr, fb_we, fb_addr, fb_data,
           vga_plot, vga_x, vga_y, vga_colour, finished, busy
  );
endinterface

// File: rtl/blit_engine.sv
// Rectangular pixel copier: ROM/buffer -> frame buffer/VGA with clipping,
// transparency and black fill; one write stage behind the source address.
module blit_engine #(
  parameter int       SCREEN_W    = 160,
  parameter int       SCREEN_H    = 120,
  parameter int       TILE        = 8,
  parameter logic [2:0] TRANSPARENT = 3'b101,
  parameter int       STAGES      = 1
) (
  input logic         clock,
  input logic         reset,
  blit_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  typedef enum logic [1:0] {M_TILE_O, M_TILE_T, M_SCR_IN, M_SCR_OUT} mode_t;

  typedef struct packed {
    mode_t       mode;
    logic        black;
    logic [1:0]  msel;
    logic [7:0]  ox;
    logic [6:0]  oy;
    logic [14:0] base;
  } cmd_t;

  state_t state, state_d;
  cmd_t   cmd_q, cmd_new;
  logic [7:0] c, c_max;
  logic [6:0] r, r_max;
  logic       go, held, full, last, issue, clip;
  logic [8:0] dx;
  logic [7:0] dy;
  logic [14:0] dst_addr;
  logic [STAGES:1] vld_pipe;
  logic [7:0]  p_x;
  logic [6:0]  p_y;
  logic [14:0] p_addr;
  logic        wr_vld, is_out, keep;
  logic [2:0]  colour;

  assign held = bus.copy_enable | bus.print_screen;
  assign go   = held;

  always_comb begin
    cmd_new       = '0;
    cmd_new.black = bus.black;
    cmd_new.msel  = bus.memory_select;
    cmd_new.ox    = bus.origin_x;
    cmd_new.oy    = bus.origin_y;
    cmd_new.base  = bus.sprite_base;
    if (bus.print_screen)     cmd_new.mode = M_SCR_OUT;
    else if (bus.draw_stage)  cmd_new.mode = M_SCR_IN;
    else if (bus.draw_explosion | bus.draw_bomb | bus.draw_p1 | bus.draw_p2)
                              cmd_new.mode = M_TILE_T;
    else                      cmd_new.mode = M_TILE_O;
  end

  assign full  = (cmd_q.mode == M_SCR_IN) || (cmd_q.mode == M_SCR_OUT);
  assign c_max = full ? 8'(SCREEN_W - 1) : 8'(TILE - 1);
  assign r_max = full ? 7'(SCREEN_H - 1) : 7'(TILE - 1);
  assign last  = (c == c_max) && (r == r_max);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (!held) state_d = S_IDLE; else if (last) state_d = S_FLUSH;
      S_FLUSH: state_d = held ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_d;

  // Source address is combinational so the ROM returns pixel k while pixel k+1 is addressed.
  assign bus.src_addr = full ? (15'(r) * 15'(SCREEN_W) + 15'(c))
                             : (cmd_q.base + 15'(r) * 15'(TILE) + 15'(c));

  assign dx = full ? {1'b0, c} : ({1'b0, cmd_q.ox} + {1'b0, c});
  assign dy = full ? {1'b0, r} : ({1'b0, cmd_q.oy} + {1'b0, r});
  assign clip     = (dx >= 9'(SCREEN_W)) || (dy >= 8'(SCREEN_H));
  assign dst_addr = 15'(dy) * 15'(SCREEN_W) + 15'(dx);
  assign issue    = (state == S_RUN) && held && !clip;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q    <= '0;
      c        <= '0;
      r        <= '0;
      vld_pipe <= '0;
      p_x      <= '0;
      p_y      <= '0;
      p_addr   <= '0;
    end else begin
      if (state == S_IDLE && go) begin
        cmd_q <= cmd_new;
        c     <= '0;
        r     <= '0;
      end else if (state == S_RUN) begin
        if (c == c_max) begin
          c <= '0;
          r <= r + 7'd1;
        end else begin
          c <= c + 8'd1;
        end
      end
      vld_pipe[1] <= issue;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      p_x    <= dx[7:0];
      p_y    <= dy[6:0];
      p_addr <= dst_addr;
    end
  end

  assign wr_vld = vld_pipe[STAGES];
  assign is_out = (cmd_q.mode == M_SCR_OUT);
  assign colour = cmd_q.black ? 3'd0 : bus.src_data;
  // Black fill wins over transparency so a black sprite erases its whole cell.
  assign keep   = (cmd_q.mode != M_TILE_T) || cmd_q.black || (bus.src_data != TRANSPARENT);

  assign bus.fb_we      = wr_vld && !is_out && keep;
  assign bus.vga_plot   = wr_vld &&  is_out && keep;
  assign bus.fb_addr    = p_addr;
  assign bus.fb_data    = (wr_vld && !is_out) ? colour : 3'd0;
  assign bus.vga_x      = p_x;
  assign bus.vga_y      = p_y;
  assign bus.vga_colour = (wr_vld && is_out) ? colour : 3'd0;
  assign bus.finished   = (state == S_DONE);
  assign bus.busy       = (state == S_RUN) || (state == S_FLUSH);

endmodule

// File: tb/tb_blit_engine.sv
// Directed bench for blit_engine: tile/sprite/clip/full-screen copies,
// back-to-back commands, abort and async reset.
module tb_blit_engine;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  blit_engine_if bus();
  blit_engine dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  int rom_mode = 0;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clock) begin
    logic [14:0] off;
    off = bus.src_addr - 15'h100;
    if (rom_mode == 0) bus.src_data <= bus.src_addr[2:0];
    else               bus.src_data <= (off < 15'd4) ? 3'b101 : 3'b001;
  end

  int nwe, nplot, first_addr, first_data, first_cyc, last_addr, last_data;
  int minx, maxx, miny, maxy, hits, nz, lvx, lvy, lvc, fin_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cmd();
    bus.copy_enable = 0; bus.print_screen = 0; bus.memory_select = 0;
    bus.draw_stage = 0; bus.draw_tile = 0; bus.draw_explosion = 0; bus.draw_bomb = 0;
    bus.draw_p1 = 0; bus.draw_p1_hp = 0; bus.draw_p2 = 0; bus.draw_p2_hp = 0;
    bus.black = 0; bus.origin_x = 0; bus.origin_y = 0; bus.sprite_base = 0;
  endtask

  task automatic sample(input int k);
    int a, x, y;
    if (bus.fb_we) begin
      a = int'(bus.fb_addr); x = a % 160; y = a / 160;
      if (nwe == 0) begin first_addr = a; first_data = int'(bus.fb_data); first_cyc = k; end
      nwe++; last_addr = a; last_data = int'(bus.fb_data);
      if (x < minx) minx = x; if (x > maxx) maxx = x;
      if (y < miny) miny = y; if (y > maxy) maxy = y;
      if (a >= 1296 && a <= 1299) hits++;
      if (bus.fb_data != 0) nz++;
    end
    if (bus.vga_plot) begin
      nplot++; lvx = int'(bus.vga_x); lvy = int'(bus.vga_y); lvc = int'(bus.vga_colour);
    end
  endtask

  // Called at the negedge of cycle 0 with the command already driven.
  task automatic run(input int budget);
    nwe = 0; nplot = 0; first_addr = -1; first_data = -1; first_cyc = -1;
    minx = 9999; maxx = -1; miny = 9999; maxy = -1; hits = 0; nz = 0; fin_cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      sample(k);
      if (bus.finished) begin fin_cyc = k; break; end
    end
  endtask

  task automatic tile_cmd(input int ox, input int oy);
    bus.copy_enable = 1; bus.origin_x = 8'(ox); bus.origin_y = 7'(oy);
    bus.sprite_base = 15'h100;
  endtask

  initial begin
    int we_after, fin_seen, we9, busy11;
    clr_cmd();
    bus.src_data = 0;
    #1;
    chk("rst_src_addr", int'(bus.src_addr), 0);
    chk("rst_fb_we", int'(bus.fb_we), 0);
    chk("rst_vga_plot", int'(bus.vga_plot), 0);
    chk("rst_fb_addr", int'(bus.fb_addr), 0);
    chk("rst_finished", int'(bus.finished), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clock); reset = 1;
    @(negedge clock);

    // Opaque tile
    tile_cmd(16, 8); bus.draw_tile = 1;
    run(200); clr_cmd();
    chk("tileo_writes", nwe, 64);
    chk("tileo_first_addr", first_addr, 1296);
    chk("tileo_first_data", first_data, 0);
    chk("tileo_first_cyc", first_cyc, 2);
    chk("tileo_last_addr", last_addr, 2423);
    chk("tileo_last_data", last_data, 7);
    chk("tileo_fin_cyc", fin_cyc, 66);
    @(negedge clock);
    chk("tileo_fin_pulse", int'(bus.finished), 0);

    // Transparent sprite, first four pixels transparent
    rom_mode = 1;
    tile_cmd(16, 8); bus.draw_p1 = 1;
    run(200); clr_cmd();
    chk("tilet_writes", nwe, 60);
    chk("tilet_hits", hits, 0);
    @(negedge clock);
    tile_cmd(16, 8); bus.draw_p1 = 1; bus.black = 1;
    run(200); clr_cmd();
    chk("black_writes", nwe, 64);
    chk("black_nonzero", nz, 0);
    rom_mode = 0;
    @(negedge clock);

    // Clipping at bottom-right corner
    tile_cmd(156, 116); bus.draw_tile = 1;
    run(200); clr_cmd();
    chk("clip_writes", nwe, 16);
    chk("clip_minx", minx, 156); chk("clip_maxx", maxx, 159);
    chk("clip_miny", miny, 116); chk("clip_maxy", maxy, 119);
    chk("clip_fin_cyc", fin_cyc, 66);
    @(negedge clock);

    // Full-screen load then print
    bus.copy_enable = 1; bus.draw_stage = 1; bus.memory_select = 2'd1;
    run(19400); clr_cmd();
    chk("scrin_writes", nwe, 19200);
    chk("scrin_plots", nplot, 0);
    chk("scrin_fin_cyc", fin_cyc, 19202);
    @(negedge clock);
    bus.print_screen = 1;
    run(19400); clr_cmd();
    chk("scrout_plots", nplot, 19200);
    chk("scrout_fb_we", nwe, 0);
    chk("scrout_last_x", lvx, 159); chk("scrout_last_y", lvy, 119);
    chk("scrout_last_colour", lvc, 7);
    chk("scrout_fin_cyc", fin_cyc, 19202);
    @(negedge clock);

    // Back-to-back with copy_enable held
    tile_cmd(16, 8); bus.draw_tile = 1;
    run(200);
    chk("b2b_fin1", fin_cyc, 66);
    bus.draw_tile = 0; bus.draw_explosion = 1;
    @(negedge clock); chk("b2b_gap_busy", int'(bus.busy), 0);
    @(negedge clock); chk("b2b_run2_busy", int'(bus.busy), 1);
    run(200); clr_cmd();
    chk("b2b_period", (fin_cyc < 0) ? -1 : fin_cyc + 2, 67);
    @(negedge clock);

    // Abort by dropping copy_enable at RUN cycle 10
    tile_cmd(16, 8); bus.draw_tile = 1;
    we_after = 0; fin_seen = 0; we9 = 0; busy11 = -1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock);
      if (k == 9) we9 = int'(bus.fb_we);
      if (k == 11) busy11 = int'(bus.busy);
      if (k >= 11 && bus.fb_we) we_after++;
      if (bus.finished) fin_seen++;
      if (k == 10) bus.copy_enable = 0;
    end
    clr_cmd();
    chk("abort_we_before", we9, 1);
    chk("abort_busy11", busy11, 0);
    chk("abort_we_after", we_after, 0);
    chk("abort_finished", fin_seen, 0);

    // Reset mid-RUN
    tile_cmd(16, 8); bus.draw_tile = 1;
    repeat (20) @(negedge clock);
    reset = 0; #1;
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_fb_we", int'(bus.fb_we), 0);
    chk("mrst_fb_addr", int'(bus.fb_addr), 0);
    chk("mrst_src_addr", int'(bus.src_addr), 0);
    chk("mrst_vga_xy", int'({bus.vga_x, bus.vga_y}), 0);
    chk("mrst_finished", int'(bus.finished), 0);
    clr_cmd();
    @(negedge clock); reset = 1;
    @(negedge clock);
    tile_cmd(16, 8); bus.draw_tile = 1;
    run(200); clr_cmd();
    chk("post_rst_writes", nwe, 64);
    chk("post_rst_fin_cyc", fin_cyc, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
